// File: rtl/uart_prog_loader_if.sv
// Loader bus: FWFT receive-FIFO read side plus the ready-handshaked instruction-memory write port.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 32
);
  logic [7:0]        rx_dout;
  logic              rx_empty;
  logic              rx_rd_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    input  rx_dout, rx_empty, mem_ready,
    output rx_rd_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output rx_dout, rx_empty, mem_ready,
    input  rx_rd_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_prog_loader.sv
// Drains a length-prefixed little-endian byte stream from the UART RX FIFO and
// writes it as 32-bit words into instruction memory, then raises done.
module uart_prog_loader #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  uart_prog_loader_if.master bus,
  output logic               busy,
  output logic               done,
  output logic [31:0]        word_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_SIZE, S_DATA, S_WRITE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_idx;
  logic [23:0]       part;
  logic [31:0]       len;
  logic [31:0]       word;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              rd;
  logic              arm;
  logic              accept;

  // Full word as it stands once the current head byte becomes byte 3.
  assign word   = {bus.rx_dout, part};
  assign arm    = start && (state_q == S_IDLE || state_q == S_DONE);
  assign accept = (state_q == S_WRITE) && bus.mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SIZE;
      S_SIZE: begin
        rd = !bus.rx_empty;
        if (rd && byte_idx == 2'd3) state_d = (word == 32'd0) ? S_DONE : S_DATA;
      end
      S_DATA: begin
        rd = !bus.rx_empty;
        if (rd && byte_idx == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: if (bus.mem_ready) state_d = (word_cnt + 32'd1 == len) ? S_DONE : S_DATA;
      S_DONE:  if (start) state_d = S_SIZE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= 2'd0;
      part     <= 24'd0;
      len      <= 32'd0;
      word_cnt <= 32'd0;
      addr     <= ADDR_W'(BASE_ADDR);
      wdata    <= 32'd0;
    end else begin
      if (arm) begin
        byte_idx <= 2'd0;
        part     <= 24'd0;
        len      <= 32'd0;
        word_cnt <= 32'd0;
        addr     <= ADDR_W'(BASE_ADDR);
      end
      if (rd) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx != 2'd3) part[{byte_idx, 3'b000} +: 8] <= bus.rx_dout;
        else if (state_q == S_SIZE) len <= word;
        else wdata <= word;
      end
      if (accept) begin
        word_cnt <= word_cnt + 32'd1;
        addr     <= addr + ADDR_W'(4);
      end
    end
  end

  assign bus.rx_rd_en  = rd;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign busy          = (state_q == S_SIZE) || (state_q == S_DATA) || (state_q == S_WRITE);
  assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: FIFO/memory models plus a
// word-list reference of the expected memory image.
module tb_uart_prog_loader;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h1000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic [31:0] word_cnt;

  uart_prog_loader_if #(.ADDR_W(ADDR_W)) bus();

  uart_prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo_q[$];
  logic [63:0] wr_q[$];
  int gap_max = 0, gap_left = 0;
  int pops = 0, rd_viol = 0, stab_viol = 0, we_cycles = 0, stall_cycles = 0;
  int stall_word = -1, stall_left = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;

  // FIFO head and memory-ready driven between edges
  always @(negedge clk) begin
    if (gap_left > 0) begin
      gap_left = gap_left - 1;
      bus.rx_empty = 1'b1;
    end else begin
      bus.rx_empty = (fifo_q.size() == 0);
    end
    bus.rx_dout = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    if (bus.mem_we && wr_q.size() == stall_word && stall_left > 0) begin
      bus.mem_ready = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      bus.mem_ready = 1'b1;
    end
  end

  // FIFO pops, memory acceptance and protocol observations at the active edge
  always @(posedge clk) begin
    if (bus.rx_rd_en) begin
      if (bus.rx_empty || fifo_q.size() == 0) rd_viol = rd_viol + 1;
      else begin
        void'(fifo_q.pop_front());
        pops = pops + 1;
        gap_left = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      end
    end
    if (bus.mem_we) we_cycles = we_cycles + 1;
    if (bus.mem_we && bus.rx_rd_en) rd_viol = rd_viol + 1;
    if (prev_stall && (bus.mem_we !== 1'b1 || bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_data))
      stab_viol = stab_viol + 1;
    prev_stall = bus.mem_we && !bus.mem_ready;
    if (prev_stall) stall_cycles = stall_cycles + 1;
    prev_addr = bus.mem_addr;
    prev_data = bus.mem_wdata;
    if (bus.mem_we && bus.mem_ready) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
  end

  task automatic clear_obs();
    wr_q.delete();
    pops = 0; rd_viol = 0; stab_viol = 0; we_cycles = 0; stall_cycles = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) fifo_q.push_back(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_timeout done=%b want 1", name, done); end
  endtask

  task automatic wait_pops(input int n, input string name);
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (pops >= n) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_pops_timeout got %0d want %0d", name, pops, n); end
  endtask

  task automatic test_reset();
    bus.rx_empty = 1'b1; bus.rx_dout = 8'h00; bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.rx_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b want 0", bus.rx_rd_en); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== BASE) begin errors++; $display("FAIL rst_addr got %h want %h", bus.mem_addr, BASE); end
    checks++; if (bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata got %h want 0", bus.mem_wdata); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done got %b want 00", {busy, done}); end
    checks++; if (word_cnt !== 32'd0) begin errors++; $display("FAIL rst_word_cnt got %0d want 0", word_cnt); end
    rst = 1'b0;
    clear_obs();
    push_word(32'h0000_0001);
    repeat (5) @(negedge clk);
    checks++; if (pops !== 0 || busy !== 1'b0) begin errors++; $display("FAIL idle_no_pop got pops=%0d busy=%b want 0/0", pops, busy); end
    fifo_q.delete();
  endtask

  task automatic test_single_word();
    logic [7:0] s[9] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEE};
    clear_obs();
    foreach (s[i]) fifo_q.push_back(s[i]);
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    wait_done("single");
    repeat (3) @(negedge clk);
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL single_nwr got %0d want 1", wr_q.size()); end
    checks++; if (wr_q.size() > 0 && wr_q[0] !== {BASE, 32'h1234_5678}) begin errors++; $display("FAIL single_wr got %h want %h", wr_q[0], {BASE, 32'h1234_5678}); end
    checks++; if (word_cnt !== 32'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", word_cnt); end
    checks++; if (pops !== 8) begin errors++; $display("FAIL single_pops got %0d want 8", pops); end
    checks++; if (fifo_q.size() !== 1) begin errors++; $display("FAIL single_extra_left got %0d want 1", fifo_q.size()); end
    checks++; if (busy !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b we=%b want 0/0", busy, bus.mem_we); end
    fifo_q.delete();
  endtask

  task automatic test_stall();
    logic [31:0] w[3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    clear_obs();
    push_word(32'd3);
    foreach (w[i]) push_word(w[i]);
    stall_word = 1; stall_left = 5;
    pulse_start();
    wait_done("stall");
    stall_word = -1;
    checks++; if (wr_q.size() !== 3) begin errors++; $display("FAIL stall_nwr got %0d want 3", wr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wr_q.size() || wr_q[i] !== {BASE + 32'(4*i), w[i]}) begin
        errors++; $display("FAIL stall_wr%0d got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 64'h0, {BASE + 32'(4*i), w[i]});
      end
    end
    checks++; if (stall_cycles !== 5) begin errors++; $display("FAIL stall_cycles got %0d want 5", stall_cycles); end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL stall_stable got %0d want 0", stab_viol); end
    checks++; if (rd_viol !== 0) begin errors++; $display("FAIL stall_rd_viol got %0d want 0", rd_viol); end
    checks++; if (word_cnt !== 32'd3) begin errors++; $display("FAIL stall_cnt got %0d want 3", word_cnt); end
  endtask

  task automatic test_zero_len();
    clear_obs();
    push_word(32'd0);
    push_word($urandom);
    pulse_start();
    wait_done("zero");
    repeat (3) @(negedge clk);
    checks++; if (we_cycles !== 0) begin errors++; $display("FAIL zero_we got %0d want 0", we_cycles); end
    checks++; if (word_cnt !== 32'd0) begin errors++; $display("FAIL zero_cnt got %0d want 0", word_cnt); end
    checks++; if (pops !== 4 || fifo_q.size() !== 4) begin errors++; $display("FAIL zero_pops got %0d left %0d want 4/4", pops, fifo_q.size()); end
    fifo_q.delete();
  endtask

  task automatic test_random_gaps();
    logic [31:0] w[4];
    for (int r = 0; r < 3; r++) begin
      clear_obs();
      foreach (w[i]) w[i] = $urandom;
      push_word(32'd4);
      foreach (w[i]) push_word(w[i]);
      gap_max = 7;
      gap_left = $urandom_range(0, 7);
      pulse_start();
      wait_done("gaps");
      gap_max = 0;
      checks++; if (wr_q.size() !== 4) begin errors++; $display("FAIL gaps_nwr got %0d want 4", wr_q.size()); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (i >= wr_q.size() || wr_q[i] !== {BASE + 32'(4*i), w[i]}) begin
          errors++; $display("FAIL gaps_wr%0d got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 64'h0, {BASE + 32'(4*i), w[i]});
        end
      end
      checks++; if (rd_viol !== 0 || pops !== 20) begin errors++; $display("FAIL gaps_rd got viol=%0d pops=%0d want 0/20", rd_viol, pops); end
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    push_word(32'd2);
    push_word($urandom);
    push_word($urandom);
    pulse_start();
    wait_pops(6, "rstmid");
    rst = 1'b1;
    #1;
    checks++; if ({bus.rx_rd_en, bus.mem_we, busy, done} !== 4'b0000) begin errors++; $display("FAIL rstmid_ctl got %b want 0000", {bus.rx_rd_en, bus.mem_we, busy, done}); end
    checks++; if (bus.mem_addr !== BASE || word_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_addr_cnt got %h/%0d want %h/0", bus.mem_addr, word_cnt, BASE); end
    repeat (3) @(negedge clk);
    checks++; if (fifo_q.size() !== 6) begin errors++; $display("FAIL rstmid_not_drained got %0d want 6", fifo_q.size()); end
    fifo_q.delete();
    rst = 1'b0;
    clear_obs();
    push_word(32'd1);
    push_word(32'hDDCC_BBAA);
    pulse_start();
    wait_done("rstmid2");
    checks++;
    if (wr_q.size() !== 1 || wr_q[0] !== {BASE, 32'hDDCC_BBAA}) begin
      errors++; $display("FAIL rstmid_wr got n=%0d %h want %h", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'h0, {BASE, 32'hDDCC_BBAA});
    end
    checks++; if (word_cnt !== 32'd1) begin errors++; $display("FAIL rstmid_cnt got %0d want 1", word_cnt); end
  endtask

  task automatic test_restart_done();
    logic [31:0] w[2];
    clear_obs();
    push_word(32'd1);
    push_word(32'hCAFE_BABE);
    pulse_start();
    wait_done("restart");
    checks++;
    if (wr_q.size() !== 1 || wr_q[0] !== {BASE, 32'hCAFE_BABE}) begin
      errors++; $display("FAIL restart_wr got n=%0d %h want %h", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'h0, {BASE, 32'hCAFE_BABE});
    end
    checks++; if (word_cnt !== 32'd1) begin errors++; $display("FAIL restart_cnt got %0d want 1", word_cnt); end
    clear_obs();
    foreach (w[i]) w[i] = $urandom;
    push_word(32'd2);
    foreach (w[i]) push_word(w[i]);
    pulse_start();
    wait_pops(6, "middata");
    pulse_start();
    wait_done("middata");
    checks++; if (wr_q.size() !== 2) begin errors++; $display("FAIL middata_nwr got %0d want 2", wr_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= wr_q.size() || wr_q[i] !== {BASE + 32'(4*i), w[i]}) begin
        errors++; $display("FAIL middata_wr%0d got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 64'h0, {BASE + 32'(4*i), w[i]});
      end
    end
    checks++; if (word_cnt !== 32'd2 || pops !== 12) begin errors++; $display("FAIL middata_cnt got %0d pops %0d want 2/12", word_cnt, pops); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stall();
    test_zero_len();
    test_random_gaps();
    test_reset_mid();
    test_restart_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
